// File: rtl/multi_sync_debounce.sv
// Multi-channel input conditioner: synchroniser chain, debounce filter and edge pulses per channel.
// Define SYNC_FALL_PULSE_EN to add the registered fall_pulse output.
module multi_sync_debounce #(
   parameter int unsigned         CHANNELS        = 4,
   parameter int unsigned         STAGES          = 2,
   parameter int unsigned         DEBOUNCE_CYCLES = 4,
   parameter logic [CHANNELS-1:0] RESET_VAL       = '0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [CHANNELS-1:0] d_in,
   output logic [CHANNELS-1:0] q_sync,
   output logic [CHANNELS-1:0] q_stable,
   output logic [CHANNELS-1:0] rise_pulse
`ifdef SYNC_FALL_PULSE_EN
   ,
   output logic [CHANNELS-1:0] fall_pulse
`endif
);

   localparam int unsigned     CntW    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CntW-1:0] CntOne  = CntW'(1);

   // ------------------------------------------------------------------
   // Synchroniser chain: stage 0 samples the pins, last stage is q_sync.
   // ------------------------------------------------------------------
   logic [CHANNELS-1:0] sync_q [STAGES];
   logic [CHANNELS-1:0] sync_d [STAGES];

   always_comb begin
      sync_d[0] = d_in;
      for (int unsigned k = 1; k < STAGES; k++) begin
         sync_d[k] = sync_q[k-1];
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
         if (reset) begin
            sync_q[k] <= RESET_VAL;
         end else begin
            sync_q[k] <= sync_d[k];
         end
      end
   end

   assign q_sync = sync_q[STAGES-1];

   // ------------------------------------------------------------------
   // Debounce: a differing level must persist DEBOUNCE_CYCLES edges.
   // ------------------------------------------------------------------
   logic [CntW-1:0]     cnt_q [CHANNELS];
   logic [CntW-1:0]     cnt_d [CHANNELS];
   logic [CHANNELS-1:0] stable_q, stable_d;
   logic [CHANNELS-1:0] accept;
   logic [CHANNELS-1:0] rise_q, rise_d;

   always_comb begin
      accept = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         cnt_d[i] = cnt_q[i];
         if (q_sync[i] == stable_q[i]) begin
            // Returning to the accepted level discards any partial count.
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CntLast) begin
            accept[i] = 1'b1;
            cnt_d[i]  = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CntOne;
         end
      end
      stable_d = stable_q ^ accept;
      rise_d   = accept & q_sync;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stable_q <= RESET_VAL;
         rise_q   <= '0;
      end else begin
         stable_q <= stable_d;
         rise_q   <= rise_d;
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         if (reset) begin
            cnt_q[i] <= '0;
         end else begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign q_stable   = stable_q;
   assign rise_pulse = rise_q;

`ifdef SYNC_FALL_PULSE_EN
   logic [CHANNELS-1:0] fall_q, fall_d;

   assign fall_d = accept & ~q_sync;

   always_ff @(posedge clk) begin
      if (reset) begin
         fall_q <= '0;
      end else begin
         fall_q <= fall_d;
      end
   end

   assign fall_pulse = fall_q;
`endif

endmodule

// File: tb/tb_multi_sync_debounce.sv
// Scoreboard bench for multi_sync_debounce: a sample-history reference model predicts every cycle,
// a monitor compares DUT outputs one time unit after each rising edge.
module tb_multi_sync_debounce;

   localparam int unsigned  C  = 4;
   localparam int unsigned  S  = 2;
   localparam int unsigned  DC = 4;
   localparam logic [C-1:0] RV = '0;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [C-1:0] d_in = '0;
   logic [C-1:0] q_sync, q_stable, rise_pulse;
`ifdef SYNC_FALL_PULSE_EN
   logic [C-1:0] fall_pulse;
`endif

   always #5 clk = ~clk;

   multi_sync_debounce #(
      .CHANNELS       (C),
      .STAGES         (S),
      .DEBOUNCE_CYCLES(DC),
      .RESET_VAL      (RV)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .d_in      (d_in),
      .q_sync    (q_sync),
      .q_stable  (q_stable),
      .rise_pulse(rise_pulse)
`ifdef SYNC_FALL_PULSE_EN
      ,
      .fall_pulse(fall_pulse)
`endif
   );

   typedef struct packed {
      logic [C-1:0] sync;
      logic [C-1:0] stable;
      logic [C-1:0] rise;
      logic [C-1:0] fall;
   } exp_t;

   exp_t         exp_q[$];
   logic [C-1:0] din_hist[$];  // d_in samples since reset, newest at back
   logic [C-1:0] win[$];       // q_sync values seen by the filter, last DC edges
   logic [C-1:0] m_stable = RV;
   int           checks = 0;
   int           errors = 0;

   // q_sync is simply the sample taken S edges ago, or RV if not enough edges since reset.
   function automatic logic [C-1:0] model_sync();
      if (din_hist.size() >= S) return din_hist[din_hist.size() - S];
      return RV;
   endfunction

   task automatic model_edge(input logic r, input logic [C-1:0] d);
      exp_t         e;
      logic [C-1:0] flip;
      logic         all_diff;
      e = '0;
      if (r) begin
         din_hist.delete();
         win.delete();
         m_stable = RV;
      end else begin
         win.push_back(model_sync());
         if (win.size() > DC) void'(win.pop_front());
         flip = '0;
         // Level accepted when the last DC filter inputs all disagree with the stable value.
         if (win.size() == DC) begin
            for (int i = 0; i < C; i++) begin
               all_diff = 1'b1;
               foreach (win[j]) if (win[j][i] == m_stable[i]) all_diff = 1'b0;
               flip[i] = all_diff;
            end
         end
         m_stable = m_stable ^ flip;
         e.rise   = flip & m_stable;
         e.fall   = flip & ~m_stable;
         din_hist.push_back(d);
         if (din_hist.size() > S) void'(din_hist.pop_front());
      end
      e.sync   = r ? RV : model_sync();
      e.stable = m_stable;
      exp_q.push_back(e);
   endtask

   // One rising edge per call; inputs change on the falling edge.
   task automatic step(input logic r, input logic [C-1:0] d);
      reset = r;
      d_in  = d;
      model_edge(r, d);
      @(negedge clk);
   endtask

   task automatic cmp(input string name, input logic [C-1:0] act, input logic [C-1:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s at %0t: got %b want %b", name, $time, act, want);
      end
   endtask

   exp_t mon_e;
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         cmp("q_sync", q_sync, mon_e.sync);
         cmp("q_stable", q_stable, mon_e.stable);
         cmp("rise_pulse", rise_pulse, mon_e.rise);
`ifdef SYNC_FALL_PULSE_EN
         cmp("fall_pulse", fall_pulse, mon_e.fall);
`endif
      end
   end

   logic [C-1:0] rnd_d;

   initial begin
      // Reset with quiet inputs, then idle.
      repeat (2) step(1'b1, 4'b0000);
      repeat (20) step(1'b0, 4'b0000);
      // Single channel press held.
      repeat (10) step(1'b0, 4'b0001);
      repeat (8) step(1'b0, 4'b0000);
      // Short glitch on channel 1.
      repeat (3) step(1'b0, 4'b0010);
      repeat (8) step(1'b0, 4'b0000);
      // Simultaneous presses.
      repeat (8) step(1'b0, 4'b1010);
      repeat (8) step(1'b0, 4'b0000);
      // Reset mid-debounce, input kept high.
      repeat (3) step(1'b0, 4'b0001);
      step(1'b1, 4'b0001);
      repeat (10) step(1'b0, 4'b0001);
      repeat (8) step(1'b0, 4'b0000);
      // Channel 2 rise then fall.
      repeat (8) step(1'b0, 4'b0100);
      repeat (8) step(1'b0, 4'b0000);
      // Random toggling with mixed run lengths and occasional reset.
      rnd_d = '0;
      for (int n = 0; n < 1500; n++) begin
         for (int i = 0; i < C; i++) begin
            if ($urandom_range(0, 5) == 0) rnd_d[i] = ~rnd_d[i];
         end
         step(($urandom_range(0, 199) == 0), rnd_d);
      end
      step(1'b0, rnd_d);
      @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
